// File: rtl/video_scan_generator.sv
// Raster timing generator with power-of-two coordinate scaling and a strobe-enabled
// control delay line that keeps syncs aligned with a fixed-latency pixel source.
module video_scan_generator #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter logic        H_SYNC_ACTIVE = 1'b0,
    parameter logic        V_SYNC_ACTIVE = 1'b0,
    parameter int unsigned SCALE_SHIFT   = 1,
    parameter int unsigned PIPE_DEPTH    = 2,
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pixelStrobe,
    input  logic                        videoEnable,
    output logic [HW-SCALE_SHIFT-1:0]   xCoord,
    output logic [VW-SCALE_SHIFT-1:0]   yCoord,
    output logic                        coordValid,
    input  logic [DATA_WIDTH-1:0]       pixelData,
    output logic [DATA_WIDTH-1:0]       videoData,
    output logic                        hSync,
    output logic                        vSync,
    output logic                        dataEnable,
    output logic                        vBlank,
    output logic                        lineStart,
    output logic                        frameStart
);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam int unsigned   H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned   H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned   V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned   V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

    typedef struct packed {
        logic visible;
        logic h_sync;
        logic v_sync;
        logic v_blank;
        logic h_zero;
        logic frame_zero;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{1'b0, ~H_SYNC_ACTIVE, ~V_SYNC_ACTIVE, 1'b0, 1'b0, 1'b0};

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic [31:0]   h_wide;
    logic [31:0]   v_wide;
    ctrl_t         ctrl_now;
    ctrl_t         ctrl_out;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pixelStrobe) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
            end else begin
                h_count <= h_count + HW'(1);
            end
        end
    end

    // Widened copies keep the window comparisons safe when a boundary equals 2^HW.
    assign h_wide     = 32'(h_count);
    assign v_wide     = 32'(v_count);
    assign xCoord     = h_count[HW-1:SCALE_SHIFT];
    assign yCoord     = v_count[VW-1:SCALE_SHIFT];
    assign coordValid = (h_wide < H_VISIBLE) && (v_wide < V_VISIBLE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl_now            = CTRL_IDLE;
        ctrl_now.visible    = coordValid;
        ctrl_now.h_sync     = (h_wide >= H_SYNC_START && h_wide < H_SYNC_END) ? H_SYNC_ACTIVE
                                                                              : ~H_SYNC_ACTIVE;
        ctrl_now.v_sync     = (v_wide >= V_SYNC_START && v_wide < V_SYNC_END) ? V_SYNC_ACTIVE
                                                                              : ~V_SYNC_ACTIVE;
        ctrl_now.v_blank    = (v_wide >= V_VISIBLE);
        ctrl_now.h_zero     = (h_count == '0);
        ctrl_now.frame_zero = (h_count == '0) && (v_count == '0);
    end

    generate
        if (PIPE_DEPTH == 1) begin : g_direct
            assign ctrl_out = ctrl_now;
        end else begin : g_delay
            ctrl_t pipe [PIPE_DEPTH-1];

            // NOTE: the delay line is a handful of flops, not RAM, so it is reset to idle;
            // otherwise positions from before reset would reach the outputs afterwards.
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < int'(PIPE_DEPTH) - 1; i++) pipe[i] <= CTRL_IDLE;
                end else if (pixelStrobe) begin
                    pipe[0] <= ctrl_now;
                    for (int i = 1; i < int'(PIPE_DEPTH) - 1; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign ctrl_out = pipe[PIPE_DEPTH-2];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            videoData  <= '0;
            dataEnable <= 1'b0;
            vBlank     <= 1'b0;
            hSync      <= ~H_SYNC_ACTIVE;
            vSync      <= ~V_SYNC_ACTIVE;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            // Pulses are rewritten every clock so they drop on strobe-gap cycles.
            lineStart  <= pixelStrobe && ctrl_out.h_zero;
            frameStart <= pixelStrobe && ctrl_out.frame_zero;
            if (pixelStrobe) begin
                videoData  <= (ctrl_out.visible && videoEnable) ? pixelData : '0;
                dataEnable <= ctrl_out.visible;
                vBlank     <= ctrl_out.v_blank;
                hSync      <= ctrl_out.h_sync;
                vSync      <= ctrl_out.v_sync;
            end
        end
    end

endmodule
